// File: rtl/id_stage_pipe_if.sv
// Decode-stage bundle: IF-side handshake, hazard inputs and the ID/EX register outputs.
// Combinational only; carries no state.
// Flow control is valid/ready on both the IF side and the EX side; stall is sideband.
//
// Modports:
//   slave  - the decode stage itself (consumes in_*, flush, ex_*, out_ready; drives the rest)
//   master - the surrounding pipeline / bench (drives in_*, flush, ex_*, out_ready)
interface id_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    // IF -> ID
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    // Pipeline control
    logic            flush;
    logic            ex_mem_read;
    logic [4:0]      ex_rd;
    logic            stall;

    // ID/EX register
    logic            out_valid;
    logic            out_ready;
    logic [11:0]     out_controls;
    logic [XLEN-1:0] out_imm;
    logic [PC_W-1:0] out_branch_addr;
    logic [PC_W-1:0] out_pc4;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [1:0]      out_inst_size;
    logic            out_is_signed;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, ex_mem_read, ex_rd, out_ready,
        output in_ready, stall, out_valid, out_controls, out_imm, out_branch_addr,
               out_pc4, out_rs1, out_rs2, out_rd, out_inst_size, out_is_signed,
               out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, ex_mem_read, ex_rd, out_ready,
        input  in_ready, stall, out_valid, out_controls, out_imm, out_branch_addr,
               out_pc4, out_rs1, out_rs2, out_rd, out_inst_size, out_is_signed,
               out_illegal
    );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I/RV64I decode stage: decodes controls, immediate and branch target into an ID/EX register.
// Latency: one cycle (accepted on edge N, visible after edge N); throughput one instruction per cycle.
// Backpressure: in_ready drops on a load-use stall or when the full register is not consumed; flush always accepts and drops.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; clears the ID/EX register and holds in_ready low
//   bus    - id_stage_pipe_if.slave: IF handshake (in_*), flush, EX hazard info (ex_*),
//            stall, and the registered decode results (out_*)
//
// out_controls packing, MSB first:
//   {mem_read, mem_write, alu_src, mem_to_reg[1:0], alu_op[3:0], reg_write, jump[1:0]}
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    id_stage_pipe_if.slave    bus
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd_f;
    logic [2:0]  f3;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic        f7_5;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign rd_f   = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1_f  = inst[19:15];
    assign rs2_f  = inst[24:20];
    assign f7_5   = inst[30];

    // Raw 32-bit immediates, already sign-extended from inst[31] to 32 bits.
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic [1:0]      mem_to_reg;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic [1:0]      jump;
    logic            illegal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [1:0]      inst_size;
    logic            is_signed;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 2'b00;
        alu_op     = 4'b0000;
        reg_write  = 1'b0;
        jump       = 2'b00;
        illegal    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        inst_size  = 2'b00;
        is_signed  = 1'b0;
        imm32      = 32'd0;

        unique case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                alu_op    = {f7_5, f3};
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                // Only SRLI/SRAI use inst[30]; for other I-ALU ops it is immediate data.
                alu_op    = {(f3 == 3'b101) ? f7_5 : 1'b0, f3};
                uses_rs1  = 1'b1;
                imm32     = imm_i;
            end
            OPC_LOAD: begin
                mem_read   = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                uses_rs1   = 1'b1;
                inst_size  = f3[1:0];
                is_signed  = ~f3[2];
                imm32      = imm_i;
            end
            OPC_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                inst_size = f3[1:0];
                imm32     = imm_s;
            end
            OPC_BRANCH: begin
                jump     = 2'b01;
                alu_op   = {1'b1, f3};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = imm_b;
            end
            OPC_JAL: begin
                jump       = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                imm32      = imm_j;
            end
            OPC_JALR: begin
                jump       = 2'b11;
                alu_src    = 1'b1;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                uses_rs1   = 1'b1;
                imm32      = imm_i;
            end
            OPC_LUI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 4'b1111;   // pass operand B
                imm32     = imm_u;
            end
            OPC_AUIPC: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                imm32     = imm_u;
            end
            default: begin
                // Unknown opcode: controls stay zero but the word is still handshaked
                // so the exception can be raised further down the pipe.
                illegal = 1'b1;
            end
        endcase

        // Widen to XLEN: every 32-bit form above is already signed, so U-type
        // also sign-extends on RV64.
        imm_ext       = {XLEN{imm32[31]}};
        imm_ext[31:0] = imm32;
    end

    logic [11:0]     controls;
    logic [PC_W-1:0] branch_addr;
    logic [PC_W-1:0] pc4;

    assign controls    = {mem_read, mem_write, alu_src, mem_to_reg, alu_op, reg_write, jump};
    // Both sums wrap modulo 2^PC_W.
    assign branch_addr = bus.in_pc + imm_ext[PC_W-1:0];
    assign pc4         = bus.in_pc + PC_W'(32'd4);

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    logic out_valid_q;
    logic out_valid_d;
    logic rs1_hit;
    logic rs2_hit;
    logic stall;
    logic in_ready;
    logic accept;
    logic load;

    assign rs1_hit = uses_rs1 & (rs1_f == bus.ex_rd);
    assign rs2_hit = uses_rs2 & (rs2_f == bus.ex_rd);
    assign stall   = HAZARD_EN & bus.in_valid & bus.ex_mem_read &
                     (bus.ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    // flush frees the register this edge, so ready may be asserted regardless
    // of stall or downstream backpressure; the word is then discarded.
    assign in_ready = ~reset & (bus.flush | (~stall & (~out_valid_q | bus.out_ready)));
    assign accept   = bus.in_valid & in_ready;
    assign load     = accept & ~bus.flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready & out_valid_q) begin
            out_valid_d = 1'b0;   // consumed with nothing behind it: bubble
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic [11:0]     controls_q;
    logic [XLEN-1:0] imm_q;
    logic [PC_W-1:0] branch_addr_q;
    logic [PC_W-1:0] pc4_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [1:0]      inst_size_q;
    logic            is_signed_q;
    logic            illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            controls_q    <= '0;
            imm_q         <= '0;
            branch_addr_q <= '0;
            pc4_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            inst_size_q   <= '0;
            is_signed_q   <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            // Data only moves on a real load, so it stays put under backpressure
            // and keeps its last value after a flush or consume.
            if (load) begin
                controls_q    <= controls;
                imm_q         <= imm_ext;
                branch_addr_q <= branch_addr;
                pc4_q         <= pc4;
                rs1_q         <= rs1_f;
                rs2_q         <= rs2_f;
                rd_q          <= rd_f;
                inst_size_q   <= inst_size;
                is_signed_q   <= is_signed;
                illegal_q     <= illegal;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready        = in_ready;
    assign bus.stall           = stall;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_controls    = controls_q;
    assign bus.out_imm         = imm_q;
    assign bus.out_branch_addr = branch_addr_q;
    assign bus.out_pc4         = pc4_q;
    assign bus.out_rs1         = rs1_q;
    assign bus.out_rs2         = rs2_q;
    assign bus.out_rd          = rd_q;
    assign bus.out_inst_size   = inst_size_q;
    assign bus.out_is_signed   = is_signed_q;
    assign bus.out_illegal     = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed vector table, hand-written handshake sequences,
// then randomized traffic against a queue-based reference model.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .PC_W(32)) bus32 ();
    id_stage_pipe_if #(.XLEN(64), .PC_W(32)) bus64 ();

    id_stage_pipe #(.XLEN(32), .PC_W(32), .HAZARD_EN(1'b1)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32.slave));
    id_stage_pipe #(.XLEN(64), .PC_W(32), .HAZARD_EN(1'b0)) dut64 (
        .clk(clk), .reset(reset), .bus(bus64.slave));

    // The RV64 / no-hazard instance sees the same input stream.
    assign bus64.in_valid    = bus32.in_valid;
    assign bus64.in_inst     = bus32.in_inst;
    assign bus64.in_pc       = bus32.in_pc;
    assign bus64.flush       = bus32.flush;
    assign bus64.ex_mem_read = bus32.ex_mem_read;
    assign bus64.ex_rd       = bus32.ex_rd;
    assign bus64.out_ready   = bus32.out_ready;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic exmr,
                         input logic [4:0] exrd);
        bus32.in_valid    = v;
        bus32.in_inst     = inst;
        bus32.in_pc       = pc;
        bus32.out_ready   = ordy;
        bus32.flush       = fl;
        bus32.ex_mem_read = exmr;
        bus32.ex_rd       = exrd;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] ctl(input logic mr, input logic mw, input logic as,
                                        input logic [1:0] m2r, input logic [3:0] aop,
                                        input logic rw, input logic [1:0] j);
        return {mr, mw, as, m2r, aop, rw, j};
    endfunction

    // Expected registered outputs for one instruction, packed in a fixed order.
    function automatic logic [127:0] ref_out(input logic [31:0] inst, input logic [31:0] pc);
        int          w;
        int          imm;
        logic [11:0] c;
        logic [31:0] br;
        logic [1:0]  sz;
        logic        sg;
        logic        ill;
        w   = inst;
        imm = 0;
        c   = '0;
        sz  = 2'b00;
        sg  = 1'b0;
        ill = 1'b0;
        case (inst[6:0])
            7'b0110011: c = ctl(0, 0, 0, 2'b00, {inst[30], inst[14:12]}, 1, 2'b00);
            7'b0010011: begin
                c   = ctl(0, 0, 1, 2'b00, {(inst[14:12] == 3'b101) & inst[30], inst[14:12]}, 1, 2'b00);
                imm = w >>> 20;
            end
            7'b0000011: begin
                c   = ctl(1, 0, 1, 2'b01, 4'b0000, 1, 2'b00);
                imm = w >>> 20;
                sz  = inst[13:12];
                sg  = !inst[14];
            end
            7'b0100011: begin
                c   = ctl(0, 1, 1, 2'b00, 4'b0000, 0, 2'b00);
                imm = ((w >>> 25) << 5) | int'(inst[11:7]);
                sz  = inst[13:12];
            end
            7'b1100011: begin
                c   = ctl(0, 0, 0, 2'b00, {1'b1, inst[14:12]}, 0, 2'b01);
                imm = ((w >>> 31) << 12) | (int'(inst[7]) << 11) |
                      (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
            end
            7'b1101111: begin
                c   = ctl(0, 0, 0, 2'b10, 4'b0000, 1, 2'b10);
                imm = ((w >>> 31) << 20) | (int'(inst[19:12]) << 12) |
                      (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
            end
            7'b1100111: begin
                c   = ctl(0, 0, 1, 2'b10, 4'b0000, 1, 2'b11);
                imm = w >>> 20;
            end
            7'b0110111: begin
                c   = ctl(0, 0, 1, 2'b00, 4'b1111, 1, 2'b00);
                imm = w & 32'hFFFFF000;
            end
            7'b0010111: begin
                c   = ctl(0, 0, 1, 2'b00, 4'b0000, 1, 2'b00);
                imm = w & 32'hFFFFF000;
            end
            default: ill = 1'b1;
        endcase
        br = pc + imm;
        return {1'b0, c, imm[31:0], br, pc + 32'd4, inst[19:15], inst[24:20], inst[11:7], sz, sg, ill};
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [127:0] dut_out();
        return {1'b0, bus32.out_controls, bus32.out_imm, bus32.out_branch_addr, bus32.out_pc4,
                bus32.out_rs1, bus32.out_rs2, bus32.out_rd, bus32.out_inst_size,
                bus32.out_is_signed, bus32.out_illegal};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic [63:0] imm64;
        logic [31:0] br;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        sgn;
        logic        ill;
    } vec_t;

    vec_t vt[15];

    localparam logic [31:0] I_ADD = 32'h002381B3;  // add x3,x7,x2
    localparam logic [31:0] I_LW  = 32'h00812303;  // lw x6,8(x2)

    logic [6:0]     ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [127:0]   mq[$];

    initial begin
        vt[0]  = '{32'hFFD08293, 32'h100,  12'h204, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFFD, 32'h000000FD, 32'h104,  5'd5,  2'd0, 1'b0, 1'b0};
        vt[1]  = '{32'hFE208CE3, 32'h200,  12'h041, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 32'h000001F8, 32'h204,  5'd25, 2'd0, 1'b0, 1'b0};
        vt[2]  = '{32'hFE208CE3, 32'h4,    12'h041, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFFC, 32'h8,    5'd25, 2'd0, 1'b0, 1'b0};
        vt[3]  = '{I_LW,         32'h300,  12'hA84, 32'h00000008, 64'h0000000000000008, 32'h00000308, 32'h304,  5'd6,  2'd2, 1'b1, 1'b0};
        vt[4]  = '{32'hFE512E23, 32'h400,  12'h600, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'h000003FC, 32'h404,  5'd28, 2'd2, 1'b0, 1'b0};
        vt[5]  = '{32'h80000537, 32'h10,   12'h27C, 32'h80000000, 64'hFFFFFFFF80000000, 32'h80000010, 32'h14,   5'd10, 2'd0, 1'b0, 1'b0};
        vt[6]  = '{32'h12345097, 32'h1000, 12'h204, 32'h12345000, 64'h0000000012345000, 32'h12346000, 32'h1004, 5'd1,  2'd0, 1'b0, 1'b0};
        vt[7]  = '{32'h010000EF, 32'h500,  12'h106, 32'h00000010, 64'h0000000000000010, 32'h00000510, 32'h504,  5'd1,  2'd0, 1'b0, 1'b0};
        vt[8]  = '{32'h00008067, 32'h600,  12'h307, 32'h00000000, 64'h0000000000000000, 32'h00000600, 32'h604,  5'd0,  2'd0, 1'b0, 1'b0};
        vt[9]  = '{I_ADD,        32'h700,  12'h004, 32'h00000000, 64'h0000000000000000, 32'h00000700, 32'h704,  5'd3,  2'd0, 1'b0, 1'b0};
        vt[10] = '{32'h402381B3, 32'h710,  12'h044, 32'h00000000, 64'h0000000000000000, 32'h00000710, 32'h714,  5'd3,  2'd0, 1'b0, 1'b0};
        vt[11] = '{32'h40325213, 32'h800,  12'h26C, 32'h00000403, 64'h0000000000000403, 32'h00000C03, 32'h804,  5'd4,  2'd0, 1'b0, 1'b0};
        vt[12] = '{32'hFFF0E093, 32'h900,  12'h234, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'h000008FF, 32'h904,  5'd1,  2'd0, 1'b0, 1'b0};
        vt[13] = '{32'h0000007F, 32'hA00,  12'h000, 32'h00000000, 64'h0000000000000000, 32'h00000A00, 32'hA04,  5'd0,  2'd0, 1'b0, 1'b1};
        vt[14] = '{32'h0000C283, 32'hB00,  12'hA84, 32'h00000000, 64'h0000000000000000, 32'h00000B00, 32'hB04,  5'd5,  2'd0, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(1, vt[0].inst, vt[0].pc, 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst.out_valid", bus32.out_valid, 0);
        chk("rst.in_ready", bus32.in_ready, 0);
        chk("rst.regs", dut_out(), 0);
        chk("rst.imm64", bus64.out_imm, 0);
        reset = 1'b0;

        // ---------------- directed table, back-to-back ----------------
        for (int i = 0; i < 15; i++) begin
            drive(1, vt[i].inst, vt[i].pc, 1, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("vec%0d.valid", i), bus32.out_valid, 1);
            chk($sformatf("vec%0d.ctrl", i), bus32.out_controls, vt[i].ctrl);
            chk($sformatf("vec%0d.imm", i), bus32.out_imm, vt[i].imm);
            chk($sformatf("vec%0d.br", i), bus32.out_branch_addr, vt[i].br);
            chk($sformatf("vec%0d.pc4", i), bus32.out_pc4, vt[i].pc4);
            chk($sformatf("vec%0d.rd", i), bus32.out_rd, vt[i].rd);
            chk($sformatf("vec%0d.ls", i), {bus32.out_inst_size, bus32.out_is_signed, bus32.out_illegal},
                {vt[i].size, vt[i].sgn, vt[i].ill});
            chk($sformatf("vec%0d.imm64", i), bus64.out_imm, vt[i].imm64);
        end

        // ---------------- load-use hazard ----------------
        drive(1, I_ADD, 32'h700, 1, 0, 1, 5'd7);
        #1;
        chk("haz_rs1.stall", bus32.stall, 1);
        chk("haz_rs1.in_ready", bus32.in_ready, 0);
        chk("haz_off.stall64", bus64.stall, 0);
        chk("haz_off.in_ready64", bus64.in_ready, 1);
        @(negedge clk);
        chk("haz.bubble", bus32.out_valid, 0);
        drive(1, I_ADD, 32'h700, 1, 0, 0, 5'd7);
        #1;
        chk("haz_clear.in_ready", bus32.in_ready, 1);
        @(negedge clk);
        chk("haz_clear.valid", bus32.out_valid, 1);
        chk("haz_clear.regs", {bus32.out_rs1, bus32.out_rs2, bus32.out_rd}, {5'd7, 5'd2, 5'd3});
        drive(1, I_ADD, 32'h700, 1, 0, 1, 5'd2);
        #1;
        chk("haz_rs2.stall", bus32.stall, 1);
        drive(1, I_ADD, 32'h700, 1, 0, 1, 5'd0);
        #1;
        chk("haz_x0.stall", bus32.stall, 0);
        chk("haz_x0.in_ready", bus32.in_ready, 1);
        drive(1, 32'h0003B537, 32'h700, 1, 0, 1, 5'd7);  // LUI with rs1 field = 7
        #1;
        chk("haz_lui.stall", bus32.stall, 0);
        @(negedge clk);

        // ---------------- backpressure ----------------
        drive(1, I_LW, 32'h300, 1, 0, 0, 0);
        @(negedge clk);
        drive(1, I_ADD, 32'h700, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.in_ready", k), bus32.in_ready, 0);
            @(negedge clk);
            chk($sformatf("bp%0d.hold", k), {bus32.out_valid, bus32.out_controls, bus32.out_imm, bus32.out_branch_addr},
                {1'b1, 12'hA84, 32'h8, 32'h308});
        end
        drive(1, I_ADD, 32'h700, 1, 0, 0, 0);
        #1;
        chk("bp_rel.in_ready", bus32.in_ready, 1);
        @(negedge clk);
        chk("bp_rel.next", {bus32.out_valid, bus32.out_controls, bus32.out_pc4}, {1'b1, 12'h004, 32'h704});
        drive(0, I_ADD, 32'h700, 1, 0, 0, 0);
        @(negedge clk);
        chk("bp_rel.nodup", bus32.out_valid, 0);

        // ---------------- flush ----------------
        drive(1, I_LW, 32'h300, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, I_ADD, 32'h700, 0, 1, 0, 0);
        #1;
        chk("flush.in_ready", bus32.in_ready, 1);
        @(negedge clk);
        chk("flush.kill", bus32.out_valid, 0);
        drive(0, I_ADD, 32'h700, 1, 0, 0, 0);
        @(negedge clk);
        chk("flush.drop", bus32.out_valid, 0);

        // ---------------- asynchronous reset mid-run ----------------
        drive(1, I_LW, 32'h300, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst.valid", bus32.out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst.valid", bus32.out_valid, 0);
        chk("mid_rst.in_ready", bus32.in_ready, 0);
        chk("mid_rst.regs", dut_out(), 0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- randomized traffic vs reference model ----------------
        mq.delete();
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] inst;
            logic [31:0] pc;
            logic        v, ordy, fl, exmr, m_stall, m_rdy;
            logic [4:0]  exrd;
            int          sel;

            chk("rnd.valid", bus32.out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("rnd.data", dut_out(), mq[0]);

            inst = $urandom;
            sel  = $urandom_range(0, 10);
            if (sel < 9) inst[6:0] = ops[sel];
            else if (sel == 9) inst[6:0] = 7'h7F;
            else inst[6:0] = 7'h0B;
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
            pc   = $urandom;
            v    = ($urandom_range(0, 99) < 75);
            ordy = ($urandom_range(0, 99) < 70);
            fl   = ($urandom_range(0, 99) < 8);
            exmr = ($urandom_range(0, 99) < 40);
            exrd = 5'($urandom_range(0, 7));
            drive(v, inst, pc, ordy, fl, exmr, exrd);

            m_stall = v && exmr && (exrd != 0) &&
                      ((uses_rs1(inst[6:0]) && inst[19:15] == exrd) ||
                       (uses_rs2(inst[6:0]) && inst[24:20] == exrd));
            m_rdy   = fl || (!m_stall && (mq.size() == 0 || ordy));
            #1;
            chk("rnd.stall", bus32.stall, m_stall);
            chk("rnd.in_ready", bus32.in_ready, m_rdy);

            if (fl) begin
                mq.delete();
            end else begin
                if (mq.size() != 0 && ordy) void'(mq.pop_front());
                if (v && m_rdy) mq.push_back(ref_out(inst, pc));
            end
            @(negedge clk);
        end
        chk("rnd.final_valid", bus32.out_valid, mq.size() != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered RV32I/RV64I decode stage. It sits between the IF/ID latch and EX and has a valid/ready handshake on both sides. Each cycle it decodes one instruction into the 12-bit control bundle, the sign-extended immediate and the branch target, then holds the result in an ID/EX output register. It adds load-use hazard stalling and pipeline flush, which the combinational decoder does not provide.

Parameters:
XLEN, 32, datapath and immediate width (32 or 64)
PC_W, 32, program counter width
HAZARD_EN, 1, 1 = load-use stall logic enabled; 0 = hazard input ignored

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  IF supplies an instruction
in_ready  out  1  ID accepts in_inst/in_pc this cycle
in_inst  in  32  instruction word
in_pc  in  PC_W  PC of in_inst
flush  in  1  kill the instruction in the output register and the one being accepted
ex_mem_read  in  1  instruction now in EX is a load
ex_rd  in  5  destination register of the EX instruction
stall  out  1  load-use hazard detected (combinational)
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX consumes the output register
out_controls  out  12  {mem_read, mem_write, alu_src, mem_to_reg[1:0], alu_op[3:0], reg_write, jump[1:0]}
out_imm  out  XLEN  sign-extended immediate
out_branch_addr  out  PC_W  in_pc + imm, registered
out_pc4  out  PC_W  in_pc + 4, registered
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_inst_size  out  2  funct3[1:0] for load/store, else 0
out_is_signed  out  1  ~funct3[2] for loads, else 0
out_illegal  out  1  opcode not recognised

Behaviour:
- Reset: out_valid=0 and every registered output=0. While reset is high, in_ready=0.
- Latency: an instruction accepted on edge N appears on the outputs after edge N, a single cycle of latency. Throughput is one instruction per cycle.
- stall = HAZARD_EN & in_valid & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- uses_rs1 applies to all formats except LUI, AUIPC and JAL. uses_rs2 applies to OP, STORE and BRANCH.
- in_ready = flush | (~stall & (~out_valid | out_ready)).
- Output register update at each edge, highest priority first:
  - flush: out_valid<=0. The incoming word is dropped, not loaded.
  - in_valid & in_ready: the decoded word is loaded and out_valid<=1.
  - out_ready & out_valid (consumed, nothing new accepted, including during a stall): out_valid<=0, which inserts a bubble.
  - Otherwise: the register holds its value.
- Data outputs do not change while out_valid=1 and out_ready=0.
- Decode, by opcode:
  - OP 0110011: alu_src=0, reg_write=1, alu_op={f7[5],f3}.
  - OP-IMM 0010011: alu_src=1, reg_write=1, alu_op={f3==101 ? f7[5] : 0, f3}.
  - LOAD 0000011: mem_read=1, alu_src=1, mem_to_reg=01, reg_write=1, alu_op=0000.
  - STORE 0100011: mem_write=1, alu_src=1, alu_op=0000.
  - BRANCH 1100011: jump=01, alu_op={1,f3}.
  - JAL 1101111: jump=10, mem_to_reg=10, reg_write=1.
  - JALR 1100111: jump=11, alu_src=1, mem_to_reg=10, reg_write=1, alu_op=0000.
  - LUI 0110111: alu_src=1, reg_write=1, alu_op=1111 (pass B).
  - AUIPC 0010111: alu_src=1, reg_write=1, alu_op=0000.
  - Any other opcode: all controls 0 and out_illegal=1. The instruction is still handshaked.
- Immediates use standard I/S/B/U/J packing and are sign-extended from inst[31] to XLEN. U-type is {inst[31:12],12'b0}, sign-extended when XLEN=64. R-type imm=0.
- Arithmetic: out_branch_addr and out_pc4 use the low PC_W bits of imm and wrap modulo 2^PC_W.
- rd=0 with reg_write=1 passes through unchanged; EX/WB suppresses the write.
- Reset asserted mid-stream clears the register asynchronously, with no partial update.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), pc=0x100, out_ready=1 -> next cycle: out_valid=1, controls alu_src=1, reg_write=1, alu_op=0000; imm=0xFFFFFFFD; rd=5; pc4=0x104.
- BEQ with imm=-8 at pc=0x200 -> branch_addr=0x1F8, jump=01, alu_op=1000, reg_write=0. Repeat with pc=0x4 -> branch_addr=0xFFFFFFFC (wrap).
- ex_mem_read=1, ex_rd=7, in_inst=ADD x3,x7,x2 -> stall=1 and in_ready=0 for that cycle, with a bubble (out_valid=0) after consume. Drop ex_mem_read -> accepted next cycle. Same case with ex_rd=0 -> no stall.
- out_ready=0 for 3 cycles with a LW held -> outputs stable, in_ready=0. Release out_ready -> the next instruction is accepted the same cycle, with no loss or duplication.
- flush=1 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming word discarded.
- Opcode 0x7F -> out_illegal=1, controls=0. Assert reset mid-run -> out_valid=0 immediately. XLEN=64 build: LUI 0x80000 -> imm=0xFFFFFFFF80000000.
